// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell with a registered borrow
// computes a - b LSB-first over WIDTH cycles behind a start/ready handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_bit_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             diffBit_q, diffBit_d;
  logic             diffBitValid_q, diffBitValid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic cellX, cellY, cellD, cellBo;
  logic [WIDTH-1:0] resNext;

  // The single full-subtractor cell, fed by the operand LSBs and the borrow register.
  always_comb begin
    cellX  = aSh_q[0];
    cellY  = bSh_q[0];
    cellD  = cellX ^ cellY ^ brw_q;
    cellBo = (~cellX & cellY) | (~(cellX ^ cellY) & brw_q);
    resNext = {cellD, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d        = state_q;
    aSh_d          = aSh_q;
    bSh_d          = bSh_q;
    res_d          = res_q;
    aMsb_d         = aMsb_q;
    bMsb_d         = bMsb_q;
    brw_d          = brw_q;
    cnt_d          = cnt_q;
    diffBit_d      = diffBit_q;
    diffBitValid_d = 1'b0;
    diff_d         = diff_q;
    borrow_d       = borrow_q;
    overflow_d     = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d   = a;
          bSh_d   = b;
          aMsb_d  = a[WIDTH-1];
          bMsb_d  = b[WIDTH-1];
          res_d   = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diffBit_d      = cellD;
        diffBitValid_d = 1'b1;
        res_d          = resNext;
        aSh_d          = aSh_q >> 1;
        bSh_d          = bSh_q >> 1;
        brw_d          = cellBo;
        cnt_d          = cnt_q + 1'b1;
        // Results are published only on the final bit, so an aborted run leaves nothing behind.
        if (cnt_q == LAST_BIT) begin
          state_d    = DONE;
          diff_d     = resNext;
          borrow_d   = cellBo;
          overflow_d = (aMsb_q != bMsb_q) && (cellD != aMsb_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      aSh_q          <= '0;
      bSh_q          <= '0;
      res_q          <= '0;
      aMsb_q         <= 1'b0;
      bMsb_q         <= 1'b0;
      brw_q          <= 1'b0;
      cnt_q          <= '0;
      diffBit_q      <= 1'b0;
      diffBitValid_q <= 1'b0;
      diff_q         <= '0;
      borrow_q       <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      aSh_q          <= aSh_d;
      bSh_q          <= bSh_d;
      res_q          <= res_d;
      aMsb_q         <= aMsb_d;
      bMsb_q         <= bMsb_d;
      brw_q          <= brw_d;
      cnt_q          <= cnt_d;
      diffBit_q      <= diffBit_d;
      diffBitValid_q <= diffBitValid_d;
      diff_q         <= diff_d;
      borrow_q       <= borrow_d;
      overflow_q     <= overflow_d;
    end
  end

  assign ready          = (state_q == IDLE);
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign diff_bit       = diffBit_q;
  assign diff_bit_valid = diffBitValid_q;
  assign diff           = diff_q;
  assign borrow         = borrow_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial full-subtractor engine.
- Inverse arithmetic of the team's full adder (`a - b` rather than `a + b`); one single-bit full-subtractor cell is reused with a registered borrow.
- Accepts two WIDTH-bit operands on a start/ready handshake and produces the difference LSB-first over WIDTH cycles.
- Presents the serial bit stream, the parallel result, the unsigned borrow and the signed overflow flag. Sits beside the adder library for area-constrained datapaths.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  load request; sampled only when ready=1
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
ready  output  1  engine idle, start will be accepted
busy  output  1  subtraction in progress
diff_bit  output  1  serial difference bit, LSB first
diff_bit_valid  output  1  diff_bit qualifier
diff  output  WIDTH  parallel difference a-b mod 2^WIDTH
borrow  output  1  final borrow; 1 iff a<b unsigned
overflow  output  1  signed two's-complement overflow of a-b
done  output  1  one-cycle completion pulse

Behaviour:
- Single clock domain: clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff_bit=0, diff_bit_valid=0, diff=0, borrow=0, overflow=0. Operand shift registers, borrow register and bit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge: capture a and b into shift registers, clear the borrow register and the counter, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1, ready=0.
  - Each edge takes x=a_sh[0], y=b_sh[0], br=borrow register and computes d = x^y^br and bo = (~x&y) | (~(x^y)&br).
  - At the same edge: register d to diff_bit, set diff_bit_valid=1, shift d into the result MSB (right shift), shift both operands right, set borrow register=bo, increment the counter.
  - After the WIDTH-th RUN edge, go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0, ready=0.
  - diff, borrow and overflow update on the transition into DONE.
  - overflow = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operands.
  - Next edge: go to IDLE.
- Latency: start is accepted at edge E0. Bits are produced at edges E1..EW. done is high in the cycle after edge EW, i.e. W clocks after acceptance. Throughput is one operation per W+2 cycles.
- diff_bit_valid is high for exactly WIDTH consecutive cycles (after E1..EW). The last serial bit coincides with done.
- diff, borrow and overflow hold their values until the next operation's DONE; they are not cleared on start.
- start while busy, in DONE, or on the same edge that leaves DONE: ignored, no queuing.
- a and b may change freely after acceptance; the operation uses only the captured values.
- Reset mid-operation: immediate abort to reset values. No done pulse and no partial result is published.
- Arithmetic is pure modulo-2^WIDTH. Borrow is the carry-chain borrow out of the MSB cell, never derived from the result.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, start one cycle -> diff_bit sequence 0,1,1,1,1,0,0,0; done 8 clocks after acceptance; diff=0x1E, borrow=0, overflow=0.
2. a=0x00, b=0x01 -> diff=0xFF, borrow=1, overflow=0; diff_bit_valid high exactly 8 cycles.
3. a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
4. start held high continuously with operands changing every cycle -> operations accepted only from IDLE, one per 10 cycles; each result matches the operands present at its acceptance edge.
5. Assert rst asynchronously (mid-cycle) at bit 4 of a=0xFF, b=0x0F -> outputs return to reset values immediately, no done. Next start with a=0x10, b=0x20 -> diff=0xF0, borrow=1.
6. Previous result 0x1E held, new start accepted -> diff stays 0x1E until the new DONE cycle, then updates.
